// File: rtl/serv_mtimer_pkg.sv
// Shared constants for serv_mtimer: register offsets, counter width and mtimecmp reset value.
// Define SERV_MTIMER_64BIT_EN for 64-bit mtime/mtimecmp; 32-bit otherwise.
package serv_mtimer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

`ifdef SERV_MTIMER_64BIT_EN
    localparam int CNT_W = 64;
`else
    localparam int CNT_W = 32;
`endif

    // All ones keeps o_mtip low out of reset until software programs a deadline.
    localparam logic [CNT_W-1:0] MTIMECMP_RST = '1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        for (int i = 0; i < 4; i++) begin
            merge_bytes[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        end
    endfunction

endpackage

// File: rtl/serv_mtimer_if.sv
// Wishbone classic responder bus carrying serv_mtimer register accesses.
interface serv_mtimer_if;

    // cyc is combined cycle/strobe; the responder raises ack for one cycle per access,
    // one cycle after cyc, never two cycles in a row, and rdt is valid only while ack=1.
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);

endinterface

// File: rtl/serv_mtimer_prescale.sv
// Tick generator for mtime: o_tick is high once every PRESCALE clock cycles.
module serv_mtimer_prescale #(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    // With PRESCALE=1 the counter never leaves 0, so tick is constantly high.
    assign o_tick = (count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (o_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serv_mtimer.sv
// Machine timer: free-running mtime, mtimecmp and the registered mtip level, on a Wishbone port.
// Define SERV_MTIMER_64BIT_EN for 64-bit registers with a tear-free mtime_hi read shadow.
module serv_mtimer
    import serv_mtimer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    serv_mtimer_if.slave wb,
    output logic         o_mtip
);

    logic             tick;
    logic [CNT_W-1:0] mtime;
    logic [CNT_W-1:0] mtime_inc;
    logic [CNT_W-1:0] mtime_nxt;
    logic [CNT_W-1:0] mtimecmp;
    logic [CNT_W-1:0] mtimecmp_nxt;
    logic             ack;
    logic [31:0]      rdt;
    logic [31:0]      rd_data;
    logic             access;
    logic             wr_en;
    logic             rd_en;

    serv_mtimer_prescale #(.PRESCALE(PRESCALE)) u_prescale (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    // An access is acted on only while ack is low, so a held cyc is served every other cycle.
    assign access    = wb.cyc & ~ack;
    assign wr_en     = access & wb.we;
    assign rd_en     = access & ~wb.we;
    assign mtime_inc = mtime + {{(CNT_W-1){1'b0}}, tick};

`ifdef SERV_MTIMER_64BIT_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_hi_shadow <= '0;
        end else if (rd_en && (wb.adr == MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    // Written bytes override the incremented value; carries into them are dropped.
    always_comb begin
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = mtimecmp;
        if (wr_en) begin
            case (wb.adr)
                MTIME_LO:    mtime_nxt[31:0]    = merge_bytes(mtime_inc[31:0], wb.dat, wb.sel);
                MTIMECMP_LO: mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], wb.dat, wb.sel);
`ifdef SERV_MTIMER_64BIT_EN
                MTIME_HI:    mtime_nxt[63:32]    = merge_bytes(mtime_inc[63:32], wb.dat, wb.sel);
                MTIMECMP_HI: mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], wb.dat, wb.sel);
`else
                MTIME_HI, MTIMECMP_HI: ;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb.adr)
            MTIME_LO:    rd_data = mtime[31:0];
            MTIMECMP_LO: rd_data = mtimecmp[31:0];
`ifdef SERV_MTIMER_64BIT_EN
            MTIME_HI:    rd_data = mtime_hi_shadow;
            MTIMECMP_HI: rd_data = mtimecmp[63:32];
`else
            MTIME_HI, MTIMECMP_HI: rd_data = '0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            ack      <= 1'b0;
            rdt      <= '0;
            o_mtip   <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            ack      <= access;
            rdt      <= rd_en ? rd_data : 32'h0;
            o_mtip   <= (mtime >= mtimecmp);
        end
    end

    assign wb.ack = ack;
    assign wb.rdt = rdt;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer: PRESCALE=1 and PRESCALE=4 instances, read scoreboard, mtip tracking.
module tb_serv_mtimer;

`ifdef SERV_MTIMER_64BIT_EN
    localparam int CW = 64;
`else
    localparam int CW = 32;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic mtip1;
    logic mtip4;

    serv_mtimer_if wb1 ();
    serv_mtimer_if wb4 ();

    serv_mtimer #(.PRESCALE(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (wb1),
        .o_mtip  (mtip1)
    );

    serv_mtimer #(.PRESCALE(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (wb4),
        .o_mtip  (mtip4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int rel      = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference state per instance (0: PRESCALE=1, 1: PRESCALE=4).
    logic [63:0] m_val    [2];
    int          m_edge   [2];
    logic [63:0] cmp_m    [2];
    logic [31:0] shadow_m [2];
    int          presc    [2];
    logic [31:0] exp_q    [$];

    function automatic logic [63:0] mask(input logic [63:0] v);
        return (CW == 64) ? v : {32'h0, v[31:0]};
    endfunction

    function automatic logic [63:0] m_at(input int w, input int e);
        int t;
        t = (e - rel) / presc[w] - (m_edge[w] - rel) / presc[w];
        return mask(m_val[w] + 64'(t));
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic get_ack(input int w);
        return (w == 0) ? wb1.ack : wb4.ack;
    endfunction

    function automatic logic [31:0] get_rdt(input int w);
        return (w == 0) ? wb1.rdt : wb4.rdt;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rel = edge_cnt;
        for (int w = 0; w < 2; w++) begin
            m_val[w]    = '0;
            m_edge[w]   = rel;
            cmp_m[w]    = mask(64'hFFFF_FFFF_FFFF_FFFF);
            shadow_m[w] = '0;
        end
    endtask

    // Expected effect of a write accepted on the next clock edge.
    task automatic model_write(input int w, input logic [1:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [63:0] post;
        post = m_at(w, edge_cnt + 1);
        case (a)
            2'd0: post[31:0]  = bmerge(post[31:0], d, s);
            2'd1: post[63:32] = bmerge(post[63:32], d, s);
            2'd2: cmp_m[w][31:0]  = bmerge(cmp_m[w][31:0], d, s);
            default: cmp_m[w][63:32] = bmerge(cmp_m[w][63:32], d, s);
        endcase
        cmp_m[w]  = mask(cmp_m[w]);
        m_val[w]  = mask(post);
        m_edge[w] = edge_cnt + 1;
    endtask

    task automatic drive(input int w, input logic c, input logic we, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (w == 0) begin
            wb1.cyc = c; wb1.we = we; wb1.adr = a; wb1.dat = d; wb1.sel = s;
        end else begin
            wb4.cyc = c; wb4.we = we; wb4.adr = a; wb4.dat = d; wb4.sel = s;
        end
    endtask

    task automatic idle_check(input int w, input string tag);
        drive(w, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        @(posedge clk); #1;
        check({tag, " ack drop"}, get_ack(w), 1'b0);
        check({tag, " rdt idle"}, get_rdt(w), 32'h0);
    endtask

    task automatic rd(input int w, input logic [1:0] a, input string tag);
        logic [63:0] m;
        logic [31:0] e;
        case (a)
            2'd0: begin
                m = m_at(w, edge_cnt);
                shadow_m[w] = m[63:32];
                e = m[31:0];
            end
            2'd1:    e = shadow_m[w];
            2'd2:    e = cmp_m[w][31:0];
            default: e = cmp_m[w][63:32];
        endcase
        exp_q.push_back(e);
        drive(w, 1'b1, 1'b0, a, 32'h0, 4'h0);
        @(posedge clk); #1;
        check({tag, " ack"}, get_ack(w), 1'b1);
        e = exp_q.pop_front();
        check(tag, get_rdt(w), e);
        idle_check(w, tag);
    endtask

    task automatic wr_issue(input int w, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string tag);
        model_write(w, a, d, s);
        drive(w, 1'b1, 1'b1, a, d, s);
        @(posedge clk); #1;
        check({tag, " ack"}, get_ack(w), 1'b1);
        drive(w, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic wr(input int w, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
        wr_issue(w, a, d, s, tag);
        idle_check(w, tag);
    endtask

    // Valid once at least one edge has passed since the last write.
    task automatic mtip_check(input int w, input string tag);
        check(tag, (w == 0) ? mtip1 : mtip4, m_at(w, edge_cnt - 1) >= cmp_m[w]);
    endtask

    initial begin
        logic [31:0] d;
        presc[0] = 1;
        presc[1] = 4;
        drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);

        // Reset state
        #1 rst_n = 1'b0;
        #3;
        check("rst ack1", wb1.ack, 1'b0);
        check("rst rdt1", wb1.rdt, 32'h0);
        check("rst mtip1", mtip1, 1'b0);
        check("rst ack4", wb4.ack, 1'b0);
        check("rst mtip4", mtip4, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Free-run ten cycles, then read back
        repeat (10) @(posedge clk);
        #1;
        mtip_check(0, "mtip idle");
        rd(0, 2'd0, "mtime after 10");
        rd(1, 2'd0, "mtime presc4");
        rd(0, 2'd2, "mtimecmp_lo rst");
        rd(0, 2'd3, "mtimecmp_hi rst");

        // Compare crossing at 20
`ifdef SERV_MTIMER_64BIT_EN
        wr(0, 2'd3, 32'h0, 4'b1111, "wr cmp_hi 0");
`endif
        wr(0, 2'd0, 32'd5, 4'b1111, "wr mtime 5");
        wr(0, 2'd2, 32'd20, 4'b1111, "wr cmp 20");
        for (int i = 0; i < 24; i++) begin
            mtip_check(0, "mtip rise");
            @(posedge clk); #1;
        end
        check("mtip high", mtip1, 1'b1);

        // Raising mtimecmp clears mtip one cycle after the ack
        wr_issue(0, 2'd2, 32'hFFFF_FFF0, 4'b1111, "wr cmp high");
        check("mtip at ack", mtip1, 1'b1);
        idle_check(0, "wr cmp high");
        mtip_check(0, "mtip cleared");
        check("mtip low", mtip1, 1'b0);

        // cyc held six cycles: ack every other cycle, write applied three times
        for (int i = 0; i < 6; i++) begin
            check("held ack", wb1.ack, (i % 2) == 1);
            if ((i % 2) == 0) model_write(0, 2'd2, 32'h10 + 32'(i), 4'b0001);
            drive(0, 1'b1, 1'b1, 2'd2, 32'h10 + 32'(i), 4'b0001);
            @(posedge clk); #1;
        end
        idle_check(0, "held end");
        rd(0, 2'd2, "cmp after burst");

        // PRESCALE=4 wrap through all ones
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        wr(1, 2'd0, 32'hFFFF_FFFE, 4'b1111, "wr mtime4 wrap");
        for (int i = 0; i < 14; i++) begin
            mtip_check(1, "mtip4 wrap");
            @(posedge clk); #1;
        end
        rd(1, 2'd0, "mtime4 lo wrapped");
        rd(1, 2'd1, "mtime4 hi wrapped");

        // Single byte-lane write
        d = $urandom;
        wr(0, 2'd0, d, 4'b0010, "wr sel 0010");
        rd(0, 2'd0, "mtime after sel 0010");

`ifdef SERV_MTIMER_64BIT_EN
        // Shadowed high word across a carry
        wr(0, 2'd1, 32'h1, 4'b1111, "wr mtime_hi 1");
        wr(0, 2'd0, 32'hFFFF_FFFA, 4'b1111, "wr mtime_lo near wrap");
        rd(0, 2'd0, "snap lo");
        repeat (4) @(posedge clk);
        #1;
        rd(0, 2'd1, "shadow hi");
        rd(0, 2'd0, "snap lo again");
        rd(0, 2'd1, "shadow hi carried");
`else
        wr(0, 2'd1, 32'hDEAD_BEEF, 4'b1111, "wr unmapped hi");
        rd(0, 2'd1, "unmapped mtime_hi");
        rd(0, 2'd3, "unmapped mtimecmp_hi");
`endif

        // Async reset while an ack is pending and mtip is set
        wr(0, 2'd2, 32'h0, 4'b1111, "wr cmp 0");
        mtip_check(0, "mtip before rst");
        drive(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        @(posedge clk); #1;
        check("pending ack", wb1.ack, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst ack", wb1.ack, 1'b0);
        check("async rst rdt", wb1.rdt, 32'h0);
        check("async rst mtip", mtip1, 1'b0);
        check("async rst ack4", wb4.ack, 1'b0);
        drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rd(0, 2'd0, "mtime after rst");
        rd(0, 2'd2, "mtimecmp after rst");
        mtip_check(0, "mtip after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
